// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Operation codes shared by the ALU control decode, the execution
//             unit and its bench.
//  Contents : OP_W    - width of the Operation code
//             OP_*    - the six defined Operation codes
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
    localparam logic [OP_W-1:0] OP_XOR = 4'b1100;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_func.sv
`default_nettype none
// ============================================================================
//  Module   : alu_func
//  Purpose  : Purely combinational ALU function. Undefined Operation codes
//             give a zero result and raise illegal.
//  Ports    : op      in  [OP_W-1:0]   Operation code
//             a, b    in  [WIDTH-1:0]  operands
//             result  out [WIDTH-1:0]  function result
//             illegal out              op is not a defined code
//  Revision : 1.0 - initial release
// ============================================================================
module alu_func
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    logic w_slt;

    assign w_slt = ($signed(a) < $signed(b));

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;   // wraps modulo 2^WIDTH
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_XOR:  result = a ^ b;
            default: illegal = 1'b1;
        endcase
    end

endmodule : alu_func
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Two-stage pipelined execution ALU with valid/ready handshakes
//             on both sides. S1 registers the operand beat, S2 registers the
//             computed result and flags. Holds up to two beats.
//  Ports    : clk          in           clock, rising edge
//             rst          in           asynchronous active-high reset
//             in_valid     in           operand/op beat present
//             in_ready     out          unit can accept a beat this cycle
//             in_op        in  [OP_W]   Operation code
//             in_a, in_b   in  [WIDTH]  operands
//             out_valid    out          result beat present
//             out_ready    in           consumer accepts result
//             out_result   out [WIDTH]  ALU result
//             out_zero     out          out_result == 0
//             out_illegal  out          op was not a defined code
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_illegal
);

    // S1 registers
    logic             r_s1_valid;
    logic [OP_W-1:0]  r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // S2 registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_illegal;

    // S2 can take a beat when empty or when its beat leaves this cycle.
    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    // Depends only on registers and out_ready, never on in_valid.
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;

    alu_func #(
        .WIDTH (WIDTH)
    ) u_alu_func (
        .op      (r_s1_op),
        .a       (r_s1_a),
        .b       (r_s1_b),
        .result  (w_result),
        .illegal (w_illegal)
    );

    // S1: a new beat may load in the same cycle the old one advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= in_op;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: data only changes on an advance, so it is held under backpressure
    // and keeps its last value once delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_zero      <= (w_result == '0);
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_zero    = r_zero;
    assign out_illegal = r_illegal;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit. Directed scenarios plus
//             a randomized stream scored against a behavioural ALU model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_zero;
    logic          out_illegal;

    typedef struct {
        logic [W-1:0] result;
        logic         illegal;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_lat = 0;
    bit   last_acc;
    bit   last_del;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal)
    );

    // Reference: {illegal, result} from the operation table.
    function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         lt;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_XOR: r = a ^ b;
            OP_SLT: begin
                // negative < non-negative; same sign compares as unsigned
                if (a[W-1] != b[W-1]) lt = a[W-1];
                else                  lt = (a < b);
                r = lt ? 1 : 0;
            end
            default: return {1'b1, {W{1'b0}}};
        endcase
        return {1'b0, r};
    endfunction

    // One cycle, called at the falling edge: drive, sample, score, advance.
    task automatic step(input bit v, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit ordy,
                        input logic [W-1:0] er, input bit eil);
        exp_t e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        last_acc = in_valid && in_ready;
        last_del = out_valid && out_ready;
        if (last_del) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got result=%h, expected no beat", out_result);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_result !== e.result) begin
                    errors++;
                    $display("FAIL result: got %h, expected %h", out_result, e.result);
                end
                checks++;
                if (out_zero !== (e.result == 0)) begin
                    errors++;
                    $display("FAIL zero: got %b, expected %b", out_zero, (e.result == 0));
                end
                checks++;
                if (out_illegal !== e.illegal) begin
                    errors++;
                    $display("FAIL illegal: got %b, expected %b", out_illegal, e.illegal);
                end
                if (chk_lat) begin
                    checks++;
                    if (cyc - e.acc_cyc != 2) begin
                        errors++;
                        $display("FAIL latency: got %0d, expected 2", cyc - e.acc_cyc);
                    end
                end
            end
        end
        if (last_acc) sb.push_back('{er, eil, cyc});
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            step(0, '0, '0, '0, 1, '0, 0);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_result !== '0)   begin errors++; $display("FAIL rst_result: got %h, expected 0", out_result); end
        checks++; if (out_zero !== 1'b0)   begin errors++; $display("FAIL rst_zero: got %b, expected 0", out_zero); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b, expected 0", out_illegal); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    endtask

    task automatic test_basic_ops();
        chk_lat = 1;
        step(1, OP_AND, 32'h0000000F, 32'h000000F0, 1, 32'h00000000, 0);
        step(1, OP_OR,  32'h0000000F, 32'h000000F0, 1, 32'h000000FF, 0);
        step(1, OP_XOR, 32'h0000000F, 32'h000000F0, 1, 32'h000000FF, 0);
        drain();
        chk_lat = 0;
    endtask

    task automatic test_arith();
        chk_lat = 1;
        step(1, OP_ADD, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 0);
        step(1, OP_SUB, 32'h0, 32'h1, 1, 32'hFFFFFFFF, 0);
        step(1, OP_SLT, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 0);
        step(1, OP_SLT, 32'h1, 32'hFFFFFFFF, 1, 32'h0, 0);
        drain();
        chk_lat = 0;
    endtask

    task automatic test_illegal();
        step(1, 4'b0011, 32'd5, 32'd7, 1, 32'h0, 1);
        step(1, OP_ADD, 32'd2, 32'd3, 1, 32'd5, 0);
        drain();
    endtask

    task automatic test_backpressure();
        int i = 0;
        int dels = 0;
        for (int c = 0; c < 5; c++) begin
            step(1, OP_ADD, i, i, 0, 2 * i, 0);
            if (last_acc) i++;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== 32'h0 || out_zero !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b result=%h zero=%b, expected 1/0/1",
                             out_valid, out_result, out_zero);
                end
            end
        end
        #1;
        checks++; if (i != 2) begin errors++; $display("FAIL bp_accepted: got %0d, expected 2", i); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
        // Release: four deliveries on four consecutive cycles.
        for (int c = 0; c < 4; c++) begin
            if (i < 4) step(1, OP_ADD, i, i, 1, 2 * i, 0);
            else       step(0, '0, '0, '0, 1, '0, 0);
            if (last_acc) i++;
            if (last_del) dels++;
        end
        checks++; if (dels != 4) begin errors++; $display("FAIL bp_throughput: got %0d, expected 4", dels); end
        drain();
    endtask

    task automatic test_reset_mid();
        step(1, OP_ADD, 32'd1, 32'd1, 0, 32'd2, 0);
        step(1, OP_ADD, 32'd2, 32'd2, 0, 32'd4, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b, expected 0", out_valid); end
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b, expected 1", in_ready); end
        for (int c = 0; c < 5; c++) begin
            step(0, '0, '0, '0, 1, '0, 0);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_beat: got out_valid=%b, expected 0", out_valid); end
        end
    endtask

    task automatic test_random();
        logic [3:0]   ops [6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR};
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W:0]   r;
        bit           ordy, rd0, rd1;
        int           acc = 0;
        int           n = 0;
        op = OP_ADD; a = '0; b = '0;
        while ((acc < 1000 || sb.size() != 0) && n < 20000) begin
            if (n == 0 || last_acc) begin
                op = ($urandom_range(0, 3) != 0) ? ops[$urandom_range(0, 5)] : 4'($urandom);
                a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom;
                b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            end
            ordy = ($urandom_range(0, 3) != 0);
            out_ready = ordy;
            in_valid  = 1'b0;
            #1 rd0 = in_ready;
            in_valid  = 1'b1;
            #1 rd1 = in_ready;
            checks++;
            if (rd0 !== rd1) begin errors++; $display("FAIL in_ready_dep: got %b/%b, expected equal", rd0, rd1); end
            r = ref_alu(op, a, b);
            step((acc < 1000) && ($urandom_range(0, 3) != 0), op, a, b, ordy, r[W-1:0], r[W]);
            if (last_acc) acc++;
            n++;
        end
        checks++;
        if (acc != 1000 || sb.size() != 0) begin
            errors++;
            $display("FAIL random_timeout: got %0d accepted %0d pending, expected 1000/0", acc, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_arith();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Two-stage pipelined execution ALU that consumes the 4-bit Operation code produced by the datapath's ALU control decode, together with two operands.
- Produces the result, a zero flag and an illegal-op flag.
- Sits between the operand/control issue point and writeback/branch logic.
- Valid/ready handshakes on both sides allow the consumer to stall it.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand/op beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_op  input  4  Operation code.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- out_result  output  WIDTH  ALU result.
- out_zero  output  1  out_result == 0.
- out_illegal  output  1  in_op was not a defined code.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Operation encoding:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0110 SUB (A-B).
  - 0111 SLT: signed A<B, result is 1 or 0, zero-extended.
  - 1100 XOR.
  - Any other code: result 0, illegal=1, zero=1.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output. SLT uses two's-complement signed compare.
- Stage 1 (S1) registers: s1_valid, op, a, b. Stage 2 (S2) registers: out_valid, result, zero, illegal. The function is computed combinationally from the S1 registers into S2.
- Transfer rules:
  - A beat is accepted when in_valid & in_ready.
  - A beat is delivered when out_valid & out_ready.
- Stall rules:
  - s2_free = !out_valid | out_ready.
  - S1 advances into S2 when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free. This is combinational from registers and out_ready, with no dependency on in_valid.
- Same-cycle accept: S1 loads a new beat in the same cycle it advances, allowing full throughput of 1 beat/cycle.
- Latency: a beat accepted at edge N appears on the out_* ports after edge N+1 (2-cycle latency), provided there is no backpressure.
- Backpressure hold: while out_valid & !out_ready, the S2 outputs are held stable and unchanged. S1 holds its beat, and once S1 is full, in_ready=0.
- Maximum occupancy: 2 beats. Beats are never dropped or duplicated, and ordering is preserved.
- Simultaneous events: S2 delivers, S1 advances and a new beat is accepted, all on one edge. All three must occur.
- Reset values (asynchronous, immediate):
  - s1_valid=0, out_valid=0.
  - out_result=0, out_zero=0, out_illegal=0.
  - S1 data registers are cleared to 0.
  - in_ready reads 1 while rst is deasserted and both stages are empty.
- Reset mid-operation: any in-flight beats are discarded. No output beat appears for them after reset release.
- Outputs out_result/zero/illegal are meaningful only when out_valid=1. They still hold their last value when out_valid=0.

Decomposition:
- Shared package alu_pkg holds:
  - Localparams for the six Operation codes: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR.
  - The 4-bit op width constant.
- These constants are also used by the ALU control decode and by the bench.
- One sub-module, alu_func: purely combinational, takes op, a, b and produces result and illegal.
- alu_exec_unit instantiates alu_func and contains only the pipeline registers and handshake logic.

Test Plan:
- Basic ops, out_ready=1:
  - a=0x0000000F, b=0x000000F0 with ops AND/OR/XOR, back-to-back → results 0x00000000 (zero=1), 0x000000FF, 0x000000FF at cycles N+2..N+4.
- Arithmetic and wrap:
  - ADD a=0xFFFFFFFF, b=1 → result 0, zero=1.
  - SUB a=0, b=1 → 0xFFFFFFFF.
  - SLT a=0xFFFFFFFF, b=1 → result 1.
  - SLT a=1, b=0xFFFFFFFF → result 0, zero=1.
- Illegal op:
  - in_op=0011, a=5, b=7 → out_valid with result 0, zero=1, illegal=1.
  - The next legal beat (ADD 2+3) → 5, illegal=0.
- Backpressure:
  - Stream 4 ADD beats (i+i), out_ready=0 for 5 cycles → in_ready drops after 2 accepted beats.
  - Output is held stable at 0.
  - When out_ready returns to 1: results 0, 2, 4, 6 arrive in order with 1 beat/cycle throughput; no loss or duplication.
- Reset mid-stream:
  - Assert rst asynchronously (between edges) with 2 beats in flight → out_valid=0 immediately, in_ready=1 after release.
  - No stale beats appear over the following 5 cycles.
- Random throughput:
  - 1000 random beats with random in_valid/out_ready → the scoreboard against the reference model matches in order.
  - in_ready never depends on in_valid.
